// File: rtl/sram_bus_arbiter_pkg.sv
// Shared encodings for the SRAM bus arbiter.
//   state_t : arbiter FSM states
//   owner_t : which client owns the in-flight bus transaction
//   SIZE_*  : bus transfer size codes
package sram_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_t;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  localparam int STARVE_W = 4;

endpackage

// File: rtl/sram_bus_arbiter.sv
// Arbitrates one SRAM-like bus between the fetch port and the load/store port.
// Data wins by default; fetch is forced through after INST_STARVE_MAX
// consecutive data grants taken while fetch was waiting. One transaction is in
// flight at a time and the pipeline is stalled while it is outstanding.
//
// Ports:
//   clk, rst                  clock, async active-high reset
//   inst_*                    fetch client (req/addr in, addr_ok/data_ok/rdata out)
//   data_*                    load/store client (req/wr/size/addr/wdata in,
//                             addr_ok/data_ok/rdata out)
//   bus_*                     master side of the memory bus
//   stallreq_for_bus          high while a bus transaction is outstanding
//
// state | meaning
// ------+---------------------------------------------
// IDLE  | nothing in flight, a client may be granted
// REQ   | bus_req high, waiting for bus_addr_ok
// RESP  | address accepted, waiting for bus_data_ok
module sram_bus_arbiter
  import sram_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int INST_STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,
  output logic              bus_req,
  output logic              bus_wr,
  output logic [1:0]        bus_size,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_addr_ok,
  input  logic              bus_data_ok,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              stallreq_for_bus
);

  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(INST_STARVE_MAX);

  state_t              state, state_nxt;
  owner_t              owner;
  logic [STARVE_W-1:0] starve_cnt;
  logic                sel_inst, sel_data, done;
  logic                lat_wr;
  logic [1:0]          lat_size;
  logic [ADDR_W-1:0]   lat_addr;
  logic [DATA_W-1:0]   lat_wdata;

  always_comb begin
    state_nxt = state;
    sel_inst  = 1'b0;
    sel_data  = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (inst_req && (!data_req || starve_cnt == STARVE_MAX)) sel_inst = 1'b1;
        else if (data_req)                                       sel_data = 1'b1;
        if (sel_inst || sel_data) state_nxt = REQ;
      end
      REQ: begin
        if (bus_addr_ok) begin
          // Slave may answer in the address cycle; then RESP is skipped.
          if (bus_data_ok) begin
            done      = 1'b1;
            state_nxt = IDLE;
          end else begin
            state_nxt = RESP;
          end
        end
      end
      RESP: begin
        if (bus_data_ok) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign inst_addr_ok     = sel_inst;
  assign data_addr_ok     = sel_data;
  assign bus_req          = (state == REQ);
  assign stallreq_for_bus = (state != IDLE);
  assign bus_wr           = lat_wr;
  assign bus_size         = lat_size;
  assign bus_addr         = lat_addr;
  assign bus_wdata        = lat_wdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner     <= OWN_INST;
      lat_wr    <= 1'b0;
      lat_size  <= SIZE_BYTE;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else if (sel_inst) begin
      owner     <= OWN_INST;
      lat_wr    <= 1'b0;
      lat_size  <= SIZE_WORD;
      lat_addr  <= inst_addr;
      lat_wdata <= '0;
    end else if (sel_data) begin
      owner     <= OWN_DATA;
      lat_wr    <= data_wr;
      lat_size  <= data_size;
      lat_addr  <= data_addr;
      lat_wdata <= data_wdata;
    end
  end

  // Counts data grants taken while fetch was also asking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (sel_inst) begin
      starve_cnt <= '0;
    end else if (sel_data && inst_req && starve_cnt != STARVE_MAX) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst_data_ok <= 1'b0;
      data_data_ok <= 1'b0;
      inst_rdata   <= '0;
      data_rdata   <= '0;
    end else begin
      inst_data_ok <= done && (owner == OWN_INST);
      data_data_ok <= done && (owner == OWN_DATA);
      if (done && owner == OWN_INST) inst_rdata <= bus_rdata;
      if (done && owner == OWN_DATA) data_rdata <= bus_rdata;
    end
  end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
module tb_sram_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        bus_req, bus_wr;
  logic [1:0]  bus_size;
  logic [31:0] bus_addr, bus_wdata;
  logic        bus_addr_ok, bus_data_ok;
  logic [31:0] bus_rdata;
  logic        stallreq_for_bus;

  int tests_run = 0;
  int tests_failed = 0;

  sram_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .INST_STARVE_MAX(8)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok),
    .bus_rdata(bus_rdata), .stallreq_for_bus(stallreq_for_bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 2 time units after the rising edge; checks follow 1 unit later.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1;
    inst_req = 0; inst_addr = '0;
    data_req = 0; data_wr = 0; data_size = 2'd0; data_addr = '0; data_wdata = '0;
    bus_addr_ok = 0; bus_data_ok = 0; bus_rdata = '0;

    // Reset values
    #3;
    check("rst_bus_req", bus_req, 0);
    check("rst_stall", stallreq_for_bus, 0);
    check("rst_addr_ok", {inst_addr_ok, data_addr_ok}, 0);
    check("rst_data_ok", {inst_data_ok, data_data_ok}, 0);
    check("rst_bus_fields", {bus_wr, bus_size, bus_addr, bus_wdata}, 0);
    check("rst_rdata", {inst_rdata, data_rdata}, 0);
    check("rst_starve", dut.starve_cnt, 0);
    step();
    rst = 1'b0;

    // Fetch alone, zero-wait slave
    inst_req = 1; inst_addr = 32'hBFC0_0000;
    #1;
    check("f1_inst_addr_ok", inst_addr_ok, 1);
    check("f1_data_addr_ok", data_addr_ok, 0);
    check("f1_stall_c0", stallreq_for_bus, 0);
    step();
    inst_req = 0; bus_addr_ok = 1;
    #1;
    check("f1_bus_req", bus_req, 1);
    check("f1_bus_addr", bus_addr, 32'hBFC0_0000);
    check("f1_bus_wr_size", {bus_wr, bus_size}, {1'b0, 2'd2});
    check("f1_stall_req", stallreq_for_bus, 1);
    step();
    bus_addr_ok = 0; bus_data_ok = 1; bus_rdata = 32'h3C08_BFC0;
    #1;
    check("f1_resp_bus_req", bus_req, 0);
    check("f1_resp_stall", stallreq_for_bus, 1);
    check("f1_resp_no_ok", inst_data_ok, 0);
    step();
    bus_data_ok = 0; bus_rdata = 32'h0;
    #1;
    check("f1_inst_data_ok", inst_data_ok, 1);
    check("f1_inst_rdata", inst_rdata, 32'h3C08_BFC0);
    check("f1_data_data_ok", data_data_ok, 0);
    check("f1_stall_done", stallreq_for_bus, 0);
    step();
    #1;
    check("f1_pulse_width", inst_data_ok, 0);
    check("f1_rdata_hold", inst_rdata, 32'h3C08_BFC0);

    // Both request with starve_cnt=0: data store wins; addr_ok+data_ok same REQ cycle
    inst_req = 1; inst_addr = 32'hBFC0_0004;
    data_req = 1; data_wr = 1; data_size = 2'd0;
    data_addr = 32'h8000_0010; data_wdata = 32'h1234_5678;
    #1;
    check("s2_data_addr_ok", data_addr_ok, 1);
    check("s2_inst_addr_ok", inst_addr_ok, 0);
    step();
    data_req = 0; bus_addr_ok = 1; bus_data_ok = 1; bus_rdata = 32'hDEAD_BEEF;
    #1;
    check("s2_starve", dut.starve_cnt, 1);
    check("s2_bus_req", bus_req, 1);
    check("s2_bus_store", {bus_wr, bus_size, bus_addr, bus_wdata},
          {1'b1, 2'd0, 32'h8000_0010, 32'h1234_5678});
    check("s2_busy_ignore", inst_addr_ok, 0);
    step();
    bus_addr_ok = 0; bus_data_ok = 0;
    #1;
    check("s2_skip_resp_ok", data_data_ok, 1);
    check("s2_store_rdata", data_rdata, 32'hDEAD_BEEF);
    check("s2_stall_done", stallreq_for_bus, 0);
    check("s2_fetch_next", inst_addr_ok, 1);
    step();
    inst_req = 0; bus_addr_ok = 1; bus_data_ok = 1; bus_rdata = 32'h1111_2222;
    #1;
    check("s2_starve_clr", dut.starve_cnt, 0);
    check("s2_fetch_addr", bus_addr, 32'hBFC0_0004);
    step();
    bus_addr_ok = 0; bus_data_ok = 0;
    #1;
    check("s2_fetch_ok", inst_data_ok, 1);
    check("s2_fetch_rdata", inst_rdata, 32'h1111_2222);

    // Continuous contention: 8 data grants, one fetch, then data again
    inst_req = 1; inst_addr = 32'hBFC0_0008;
    data_req = 1; data_wr = 0; data_size = 2'd2; data_addr = 32'h8000_0100;
    bus_addr_ok = 1; bus_data_ok = 1; bus_rdata = 32'h5555_AAAA;
    for (int i = 0; i < 10; i++) begin
      #1;
      check($sformatf("c3_inst_grant_%0d", i), inst_addr_ok, (i == 8));
      check($sformatf("c3_data_grant_%0d", i), data_addr_ok, (i != 8));
      if (i == 9) check("c3_fetch_done", inst_data_ok, 1);
      step();
      #1;
      check($sformatf("c3_starve_%0d", i), dut.starve_cnt,
            (i < 8) ? i + 1 : ((i == 8) ? 0 : 1));
      if (i == 9) begin
        inst_req = 0; data_req = 0;
      end
      step();
    end
    bus_addr_ok = 0; bus_data_ok = 0;
    #1;
    check("c3_last_data_ok", data_data_ok, 1);

    // Slow slave: 3 wait cycles on addr_ok, 2 on data_ok
    data_req = 1; data_wr = 0; data_size = 2'd1; data_addr = 32'h8000_0020;
    #1;
    check("w4_data_addr_ok", data_addr_ok, 1);
    step();
    data_req = 0; data_addr = 32'hFFFF_FFFF; data_size = 2'd3;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("w4_req_wait_%0d", k), {bus_req, stallreq_for_bus}, 2'b11);
      check($sformatf("w4_addr_stable_%0d", k), {bus_size, bus_addr}, {2'd1, 32'h8000_0020});
      step();
    end
    bus_addr_ok = 1;
    #1;
    check("w4_req_accept", bus_req, 1);
    step();
    bus_addr_ok = 0;
    for (int k = 0; k < 2; k++) begin
      #1;
      check($sformatf("w4_resp_wait_%0d", k), {bus_req, stallreq_for_bus, data_data_ok}, 3'b010);
      step();
    end
    bus_data_ok = 1; bus_rdata = 32'hCAFE_F00D;
    #1;
    check("w4_resp_stall", stallreq_for_bus, 1);
    step();
    bus_data_ok = 0; bus_rdata = 32'h0;
    #1;
    check("w4_data_ok", data_data_ok, 1);
    check("w4_data_rdata", data_rdata, 32'hCAFE_F00D);
    check("w4_stall_done", stallreq_for_bus, 0);

    // Reset in RESP abandons the transaction
    inst_req = 1; inst_addr = 32'hBFC0_0010;
    data_req = 1; data_wr = 1; data_size = 2'd2; data_addr = 32'h8000_0040; data_wdata = 32'hA5A5_A5A5;
    #1;
    check("r5_data_addr_ok", data_addr_ok, 1);
    step();
    inst_req = 0; data_req = 0; bus_addr_ok = 1;
    #1;
    check("r5_starve", dut.starve_cnt, 2);
    step();
    bus_addr_ok = 0;
    #1;
    check("r5_in_resp", {bus_req, stallreq_for_bus}, 2'b01);
    rst = 1'b1;
    #1;
    check("r5_async_stall", stallreq_for_bus, 0);
    check("r5_async_bus_req", bus_req, 0);
    check("r5_async_starve", dut.starve_cnt, 0);
    check("r5_async_fields", {bus_wr, bus_addr, bus_wdata}, 0);
    check("r5_async_rdata", {inst_rdata, data_rdata}, 0);
    step();
    rst = 1'b0;
    #1;
    check("r5_no_ok_0", {inst_data_ok, data_data_ok}, 0);
    step();
    #1;
    check("r5_no_ok_1", {inst_data_ok, data_data_ok, stallreq_for_bus}, 0);

    inst_req = 1; inst_addr = 32'hBFC0_0000;
    #1;
    check("r5_fetch_addr_ok", inst_addr_ok, 1);
    step();
    inst_req = 0; bus_addr_ok = 1;
    #1;
    check("r5_fetch_bus", {bus_req, bus_wr, bus_size, bus_addr}, {1'b1, 1'b0, 2'd2, 32'hBFC0_0000});
    step();
    bus_addr_ok = 0; bus_data_ok = 1; bus_rdata = 32'h2408_0001;
    step();
    bus_data_ok = 0;
    #1;
    check("r5_fetch_ok", inst_data_ok, 1);
    check("r5_fetch_rdata", inst_rdata, 32'h2408_0001);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/sram_bus_arbiter.md
# sram_bus_arbiter

Shares the single SRAM-like memory bus between the instruction-fetch port (IF stage) and the data port (MEM stage). The block grants one requester at a time under data-first priority with an anti-starvation override for fetch. It keeps exactly one bus transaction in flight and raises a stall request to the pipeline controller while a transaction is outstanding.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- INST_STARVE_MAX, 8, consecutive data grants with fetch waiting before fetch is forced to win; legal range 1..15

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- inst_req  in  1  fetch request
- inst_addr  in  ADDR_W  fetch address
- inst_addr_ok  out  1  fetch request accepted this cycle
- inst_data_ok  out  1  fetch data valid, one-cycle pulse
- inst_rdata  out  DATA_W  fetch read data
- data_req  in  1  load/store request
- data_wr  in  1  1 = store
- data_size  in  2  0 = byte, 1 = half, 2 = word
- data_addr  in  ADDR_W  load/store address
- data_wdata  in  DATA_W  store data
- data_addr_ok  out  1  data request accepted this cycle
- data_data_ok  out  1  load data valid or store done, one-cycle pulse
- data_rdata  out  DATA_W  load data
- bus_req, bus_wr  out  1  bus request, bus write
- bus_size  out  2  bus size
- bus_addr  out  ADDR_W  bus address
- bus_wdata  out  DATA_W  bus write data
- bus_addr_ok, bus_data_ok  in  1  slave handshakes
- bus_rdata  in  DATA_W  slave read data
- stallreq_for_bus  out  1  pipeline stall request to the controller

## Operation
- States:
  - IDLE: no request in flight.
  - REQ: bus_req asserted, waiting for bus_addr_ok.
  - RESP: waiting for bus_data_ok.
- IDLE, selection:
  - Fetch is selected if inst_req is high and either data_req is low or starve_cnt == INST_STARVE_MAX.
  - Otherwise data is selected if data_req is high.
- IDLE, on selection:
  - The selected port's addr_ok is driven high combinationally in the same cycle.
  - On the clock edge, owner and the request fields (wr, size, addr, wdata) are latched and the state moves to REQ.
  - Fetch requests latch wr=0 and size=2.
- REQ:
  - bus_req is 1, and the bus fields come from the latched registers and stay stable.
  - bus_addr_ok alone moves the state to RESP.
  - bus_addr_ok together with bus_data_ok completes the transaction directly and moves the state to IDLE.
- RESP: bus_data_ok completes the transaction and moves the state to IDLE.
- Completion:
  - On the next cycle, owner's data_ok is 1 for exactly one cycle.
  - Owner's rdata holds the bus_rdata captured at completion and keeps that value until the next completion for the same port.
  - Store completions update data_rdata with whatever bus_rdata was; consumers ignore it.
- starve_cnt:
  - Width is 4 bits.
  - Increments, saturating at INST_STARVE_MAX, on each data grant while inst_req is 1.
  - Clears on any fetch grant.
  - Unchanged otherwise.
- stallreq_for_bus is 1 in REQ and RESP, and 0 in IDLE, including the data_ok pulse cycle.
- Requests arriving outside IDLE are ignored; addr_ok stays 0, and the requester holds its request.

## Timing
- Reset values:
  - State is IDLE, starve_cnt = 0.
  - bus_req, bus_wr, all addr_ok/data_ok and stallreq_for_bus are 0.
  - bus_size, bus_addr, bus_wdata, inst_rdata and data_rdata are 0.
- Reset mid-transaction:
  - The transaction is abandoned, and the outputs take their reset values immediately (asynchronous).
  - No data_ok is produced for it.
  - The bus slave shares rst.
- Latency with a zero-wait slave (addr_ok in the first REQ cycle, data_ok in the first RESP cycle):
  - Cycle 0: client request and addr_ok (IDLE).
  - Cycle 1: REQ.
  - Cycle 2: RESP.
  - Cycle 3: client data_ok (IDLE).
  - A new grant is possible in cycle 3.
- Every wait cycle of the slave adds one cycle.
- At most one bus transaction is outstanding, and inst_addr_ok and data_addr_ok are never 1 together.

## Structure
- Shared package/defines file holds:
  - State encodings IDLE=2'd0, REQ=2'd1, RESP=2'd2.
  - Owner encoding OWN_INST=1'b0, OWN_DATA=1'b1.
  - Size encodings.
- Single module; no sub-module. The starvation counter is inline.

## Test plan
- Fetch alone at 0xBFC00000 with a zero-wait slave: inst_addr_ok in cycle 0, bus_req in cycle 1 with bus_addr=0xBFC00000, wr=0, size=2; inst_data_ok in cycle 3 with inst_rdata equal to bus_rdata (0x3C08BFC0).
- inst_req and data_req both high in IDLE with starve_cnt=0: data_addr_ok=1 and inst_addr_ok=0; the store (addr 0x80000010, wdata 0x12345678, size 0) appears on the bus; starve_cnt=1.
- Both ports requesting continuously, INST_STARVE_MAX=8: exactly 8 data grants, then one fetch grant, then starve_cnt=0 and data wins again.
- Slave stalls bus_addr_ok for 3 cycles and bus_data_ok for 2: bus fields stay constant; stallreq_for_bus stays 1 throughout REQ and RESP; data_ok arrives 1 cycle after bus_data_ok.
- bus_addr_ok and bus_data_ok in the same REQ cycle: RESP is skipped; data_ok follows on the next cycle.
- rst asserted in RESP: bus_req, stallreq_for_bus and starve_cnt drop to 0 without a clock edge; no data_ok follows; a new fetch after reset completes normally.
